pu_riscv_ahb3_sram_slave: RTL and testbench

PU_RISCV_AHB3_SRAM_SLAVE -- requirements
Module: pu_riscv_ahb3_sram_slave

---
 rtl/pu_riscv_ahb3_sram_slave.sv | 152 +++++++++++++++
 tb/tb_pu_riscv_ahb3_sram_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_riscv_ahb3_sram_slave.sv
// AHB3-Lite SRAM slave: word-organised memory with byte lanes, optional data-phase
// wait states, two-cycle ERROR response and write-to-read forwarding.
module pu_riscv_ahb3_sram_slave #(
  parameter int unsigned MEM_SIZE    = 4096,
  parameter int unsigned HADDR_SIZE  = 32,
  parameter int unsigned HDATA_SIZE  = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int unsigned BYTES = 4;
  localparam int unsigned WORDS = MEM_SIZE / BYTES;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMP_W = HADDR_SIZE + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               ready_nxt, resp_nxt;

  logic               step, accept, addr_err, wr_commit;
  logic [IDX_W-1:0]   addr_idx;
  logic [BYTES-1:0]   addr_be;
  logic [31:0]        fwd_word;

  logic               wr_pend_q;
  logic [IDX_W-1:0]   wr_idx_q;
  logic [BYTES-1:0]   wr_be_q;

  logic [31:0]        mem [WORDS];

  logic               unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  function automatic logic [BYTES-1:0] lane_mask(input logic [2:0] size, input logic [1:0] ofs);
    case (size)
      3'd0:    lane_mask = 4'b0001 << ofs;
      3'd1:    lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // A ready cycle with HREADY high ends the current data phase and opens an address phase;
  // a ready cycle with HREADY low means another slave is stalling the bus, so everything holds.
  assign step      = HREADYOUT & HREADY;
  assign accept    = step & HSEL & HTRANS[1];
  assign wr_commit = step & wr_pend_q;
  assign addr_idx  = HADDR[IDX_W+1:2];
  assign addr_be   = lane_mask(HSIZE, HADDR[1:0]);

  assign addr_err = ({1'b0, HADDR} >= CMP_W'(MEM_SIZE))
                  | (HSIZE > 3'd2)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  // Read word merged with the bytes of a write committing on the same edge.
  always_comb begin
    fwd_word = mem[addr_idx];
    for (int b = 0; b < BYTES; b++) begin
      if (wr_commit && (wr_idx_q == addr_idx) && wr_be_q[b]) fwd_word[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  // State register, data-phase bookkeeping and registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      wr_be_q   <= '0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      HREADYOUT <= ready_nxt;
      HRESP     <= resp_nxt;
      if (step) wr_pend_q <= accept & ~addr_err & HWRITE;
      if (accept && !addr_err) begin
        wr_idx_q <= addr_idx;
        wr_be_q  <= addr_be;
        if (!HWRITE) HRDATA <= fwd_word;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_ERR1: state_nxt = ST_ERR2;
      ST_WAIT: if (cnt_q != '0) cnt_nxt = cnt_q - CNT_W'(1);
      default: ;
    endcase
    if (step) begin
      state_nxt = ST_IDLE;
      if (accept) begin
        if (addr_err) begin
          state_nxt = ST_ERR1;
        end else if (WAIT_STATES != 0) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_W'(WAIT_STATES);
        end
      end
    end
  end

  // Output decode of the upcoming state, registered above.
  always_comb begin
    ready_nxt = 1'b1;
    resp_nxt  = 1'b0;
    case (state_nxt)
      ST_WAIT: ready_nxt = (cnt_nxt == '0);
      ST_ERR1: begin
        ready_nxt = 1'b0;
        resp_nxt  = 1'b1;
      end
      ST_ERR2: resp_nxt = 1'b1;
      default: ;
    endcase
  end

  // Memory array has no reset; writes land when their data phase ends.
  always_ff @(posedge HCLK) begin
    if (wr_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be_q[b]) mem[wr_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_pu_riscv_ahb3_sram_slave.sv
// Scoreboard bench for the AHB3 SRAM slave: instance 0 has no wait states, instance 1 has three.
module tb_pu_riscv_ahb3_sram_slave;

  typedef struct {
    bit          resp;
    int          waits;
    bit          chk;
    logic [31:0] data;
    int          id;
  } exp_t;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic [1:0]        hsel;
  logic [1:0][31:0]  haddr;
  logic [1:0][31:0]  hwdata;
  logic [1:0][31:0]  hrdata;
  logic [1:0]        hwrite;
  logic [1:0][2:0]   hsize;
  logic [1:0][1:0]   htrans;
  logic [1:0]        hready;
  logic [1:0]        hreadyout;
  logic [1:0]        hresp;
  logic [1:0]        ext_stall;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   xid = 0;
  bit   act [2];
  int   wcnt [2];

  always #5 HCLK = ~HCLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pu_riscv_ahb3_sram_slave #(
      .MEM_SIZE(4096), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES((g == 0) ? 0 : 3)
    ) u_dut (
      .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(hsel[g]), .HADDR(haddr[g]),
      .HWDATA(hwdata[g]), .HRDATA(hrdata[g]), .HWRITE(hwrite[g]), .HSIZE(hsize[g]),
      .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(htrans[g]), .HMASTLOCK(1'b0),
      .HREADY(hready[g]), .HREADYOUT(hreadyout[g]), .HRESP(hresp[g])
    );
    assign hready[g] = hreadyout[g] & ~ext_stall[g];
  end

  function automatic void chk(input string name, input int g, input int id,
                              input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst%0d xfer%0d got=%h want=%h", name, g, id, got, want);
    end
  endfunction

  function automatic int qsize(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int g);
    return (g == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpop(input int g);
    if (g == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void qpush(input int g, input exp_t e);
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void qflush(input int g);
    if (g == 0) q0.delete();
    else        q1.delete();
  endfunction

  // Monitor: tracks data phases from the bus signals and scores each completion.
  always @(negedge HCLK) begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      if (!HRESETn) begin
        act[g] = 1'b0;
        qflush(g);
      end else begin
        if (act[g]) begin
          if (qsize(g) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_data_phase inst%0d got=data_phase want=none", g);
            act[g] = 1'b0;
          end else begin
            e = qfront(g);
            if (hreadyout[g]) begin
              qpop(g);
              chk("resp", g, e.id, 32'(hresp[g]), 32'(e.resp));
              chk("wait_cycles", g, e.id, 32'(wcnt[g]), 32'(e.waits));
              if (e.chk) chk("rdata", g, e.id, hrdata[g], e.data);
            end else begin
              wcnt[g]++;
              chk("stall_resp", g, e.id, 32'(hresp[g]), 32'(e.resp));
            end
          end
        end else begin
          chk("idle_ready", g, -1, 32'(hreadyout[g]), 32'd1);
          chk("idle_resp", g, -1, 32'(hresp[g]), 32'd0);
        end
        if (hreadyout[g]) begin
          act[g]  = hready[g] & hsel[g] & htrans[g][1];
          wcnt[g] = 0;
        end
      end
    end
  end

  // Issue one address phase; returns just after the accepting edge with HWDATA driven.
  task automatic xfer(input int g, input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit err, input logic [31:0] rexp,
                      input int stall);
    exp_t e;
    int   n;
    e.resp  = err;
    e.waits = err ? 1 : ((g == 0) ? 0 : 3);
    e.chk   = !wr && !err;
    e.data  = rexp;
    e.id    = xid;
    xid++;
    qpush(g, e);
    hsel[g]   = 1'b1;
    htrans[g] = 2'b10;
    haddr[g]  = addr;
    hwrite[g] = wr;
    hsize[g]  = sz;
    if (stall > 0) begin
      ext_stall[g] = 1'b1;
      repeat (stall) @(posedge HCLK);
      #1;
      ext_stall[g] = 1'b0;
    end
    n = 0;
    forever begin
      @(negedge HCLK);
      if (hready[g]) break;
      n++;
      if (n > 64) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout inst%0d xfer%0d got=no_hready want=hready", g, e.id);
        break;
      end
    end
    @(posedge HCLK);
    #1;
    hwdata[g] = wdata;
    hsel[g]   = 1'b0;
    htrans[g] = 2'b00;
  endtask

  task automatic drain(input int g);
    int n;
    n = 0;
    while (qsize(g) != 0 && n < 64) begin
      @(negedge HCLK);
      n++;
    end
    if (qsize(g) != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout inst%0d got=%0d pending want=0", g, qsize(g));
    end
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    hsel = '0; haddr = '0; hwdata = '0; hwrite = '0; hsize = '0; htrans = '0; ext_stall = '0;
    act[0] = 1'b0; act[1] = 1'b0; wcnt[0] = 0; wcnt[1] = 0;
    #12;
    for (int g = 0; g < 2; g++) begin
      chk("rst_ready", g, -1, 32'(hreadyout[g]), 32'd1);
      chk("rst_resp", g, -1, 32'(hresp[g]), 32'd0);
      chk("rst_rdata", g, -1, hrdata[g], 32'd0);
    end
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Zero-wait instance: writes, lane merging, forwarding, stalls and errors.
    xfer(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
    xfer(0, 0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);
    xfer(0, 1, 3'd0, 32'h11, 32'h11225533, 0, 32'h0, 0);
    xfer(0, 0, 3'd2, 32'h10, 32'h0, 0, 32'hDEAD55EF, 0);
    xfer(0, 0, 3'd2, 32'h10, 32'h0, 0, 32'hDEAD55EF, 0);
    xfer(0, 1, 3'd1, 32'h12, 32'h12349999, 0, 32'h0, 0);
    @(posedge HCLK);
    #1;
    xfer(0, 0, 3'd2, 32'h10, 32'h0, 0, 32'h123455EF, 2);
    xfer(0, 1, 3'd2, 32'h0, 32'hA5A5A5A5, 0, 32'h0, 0);
    xfer(0, 0, 3'd2, 32'h1000, 32'h0, 1, 32'h0, 0);
    xfer(0, 1, 3'd1, 32'h3, 32'hFFFFFFFF, 1, 32'h0, 0);
    xfer(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'hA5A5A5A5, 0);
    xfer(0, 1, 3'd3, 32'h0, 32'h0, 1, 32'h0, 0);
    xfer(0, 0, 3'd0, 32'h13, 32'h0, 0, 32'h123455EF, 0);
    xfer(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'hA5A5A5A5, 0);
    drain(0);

    // Three-wait instance: wait counting, error and reset abort of a pending write.
    xfer(1, 1, 3'd2, 32'h20, 32'h12345678, 0, 32'h0, 0);
    xfer(1, 0, 3'd2, 32'h20, 32'h0, 0, 32'h12345678, 0);
    xfer(1, 0, 3'd2, 32'h1000, 32'h0, 1, 32'h0, 0);
    drain(1);
    xfer(1, 1, 3'd2, 32'h20, 32'hCAFEF00D, 0, 32'h0, 0);
    @(negedge HCLK);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("abort_ready", 1, -1, 32'(hreadyout[1]), 32'd1);
    chk("abort_resp", 1, -1, 32'(hresp[1]), 32'd0);
    chk("abort_rdata", 1, -1, hrdata[1], 32'd0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    xfer(1, 0, 3'd2, 32'h20, 32'h0, 0, 32'h12345678, 0);
    drain(1);
    xfer(0, 0, 3'd2, 32'h10, 32'h0, 0, 32'h123455EF, 0);
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
